// File: rtl/systolic_array_ws_if.sv
// ---------------------------------------------------------------------------
// systolic_array_ws_if
// Stream bundle for the weight-stationary systolic array.
//   wgt_valid/wgt_ready/wgt_data       : one weight row per beat
//                                         (element n at [n*WGT_DATA_WIDTH +: WGT_DATA_WIDTH])
//   in_valid/in_ready/in_data/in_last  : one input vector per beat
//                                         (element m at [m*INP_DATA_WIDTH +: INP_DATA_WIDTH])
//   out_valid/out_ready/out_data/out_last : one result vector per beat
//                                         (column n at [n*ACC_WIDTH +: ACC_WIDTH])
// master : producer of weights/inputs and consumer of results (buffer side)
// slave  : the array itself
// ---------------------------------------------------------------------------
interface systolic_array_ws_if #(
    parameter int ARRAY_M        = 4,
    parameter int ARRAY_N        = 4,
    parameter int INP_DATA_WIDTH = 8,
    parameter int WGT_DATA_WIDTH = 8,
    parameter int ACC_WIDTH      = INP_DATA_WIDTH + WGT_DATA_WIDTH + $clog2(ARRAY_M)
);
    logic                                wgt_valid;
    logic                                wgt_ready;
    logic [ARRAY_N*WGT_DATA_WIDTH-1:0]   wgt_data;

    logic                                in_valid;
    logic                                in_ready;
    logic [ARRAY_M*INP_DATA_WIDTH-1:0]   in_data;
    logic                                in_last;

    logic                                out_valid;
    logic                                out_ready;
    logic [ARRAY_N*ACC_WIDTH-1:0]        out_data;
    logic                                out_last;

    modport master (
        output wgt_valid, wgt_data, in_valid, in_data, in_last, out_ready,
        input  wgt_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  wgt_valid, wgt_data, in_valid, in_data, in_last, out_ready,
        output wgt_ready, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/systolic_array_ws.sv
// ---------------------------------------------------------------------------
// systolic_array_ws
// Weight-stationary ARRAY_M x ARRAY_N MAC array with weight loading, input
// skew, output deskew and valid/ready flow control on every stream.
// Each accepted input vector yields out[n] = sum_m in[m] * W[m][n], presented
// ARRAY_M + ARRAY_N cycles after acceptance when not back-pressured.
//
// Ports:
//   clk           : clock
//   reset         : synchronous, active-high
//   load_start    : pulse in IDLE, starts loading ARRAY_M weight rows
//   compute_start : pulse in IDLE, starts a compute pass with stored weights
//   busy          : high whenever the controller is not IDLE
//   bus           : stream bundle (slave side), see systolic_array_ws_if
//
// Build option: define SYSTOLIC_RELU_EN to clamp negative results to zero at
// the deskew output register (no added latency).
// ---------------------------------------------------------------------------
module systolic_array_ws #(
    parameter int ARRAY_M        = 4,
    parameter int ARRAY_N        = 4,
    parameter int INP_DATA_WIDTH = 8,
    parameter int WGT_DATA_WIDTH = 8,
    parameter int ACC_WIDTH      = INP_DATA_WIDTH + WGT_DATA_WIDTH + $clog2(ARRAY_M)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 compute_start,
    output logic                 busy,
    systolic_array_ws_if.slave   bus
);
    localparam int LAT    = ARRAY_M + ARRAY_N;
    localparam int CNT_W  = $clog2(LAT + 1);
    localparam int ROW_W  = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;
    localparam int PROD_W = INP_DATA_WIDTH + WGT_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic [ROW_W-1:0]     row_reg;
    logic [CNT_W-1:0]     inflight_reg;
    logic [LAT:0]         valid_pipe_reg;
    logic [LAT:0]         last_pipe_reg;

    logic stall, advance, in_fire, wgt_fire, out_fire;

    // The whole pipeline freezes while a presented result is not taken.
    assign stall    = bus.out_valid && !bus.out_ready;
    assign advance  = !stall;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign wgt_fire = bus.wgt_valid && bus.wgt_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    function automatic logic signed [ACC_WIDTH-1:0] out_fn(input logic signed [ACC_WIDTH-1:0] s);
`ifdef SYSTOLIC_RELU_EN
        return s[ACC_WIDTH-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_start)         state_next = LOAD;
                else if (compute_start) state_next = COMPUTE;
            end
            LOAD:    if (wgt_fire && row_reg == ROW_W'(ARRAY_M - 1)) state_next = COMPUTE;
            COMPUTE: if (in_fire && bus.in_last) state_next = DRAIN;
            DRAIN:   if (inflight_reg == '0 && !bus.out_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.wgt_ready = (state_reg == LOAD);
        bus.in_ready  = (state_reg == COMPUTE) && !stall;
        busy          = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset)                              row_reg <= '0;
        else if (state_reg == IDLE && load_start) row_reg <= '0;
        else if (wgt_fire)                      row_reg <= row_reg + ROW_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_reg <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
                2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // valid/last tags ride alongside the data; the top bit is the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe_reg <= '0;
            last_pipe_reg  <= '0;
        end else if (advance) begin
            valid_pipe_reg <= {valid_pipe_reg[LAT-1:0], in_fire};
            last_pipe_reg  <= {last_pipe_reg[LAT-1:0], in_fire && bus.in_last};
        end
    end

    assign bus.out_valid = valid_pipe_reg[LAT];
    assign bus.out_last  = last_pipe_reg[LAT];

    // ---------------- input skew ----------------
    logic signed [INP_DATA_WIDTH-1:0] skew_out [ARRAY_M];

    for (genvar gi = 0; gi < ARRAY_M; gi++) begin : g_skew
        // Row gi sees gi extra stages so its element meets the partial sum
        // coming down column 0 at the right cycle. Bubbles enter as zero.
        logic signed [INP_DATA_WIDTH-1:0] skew_reg [0:gi];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= gi; k++) skew_reg[k] <= '0;
            end else if (advance) begin
                skew_reg[0] <= in_fire ? bus.in_data[gi*INP_DATA_WIDTH +: INP_DATA_WIDTH] : '0;
                for (int k = 1; k <= gi; k++) skew_reg[k] <= skew_reg[k-1];
            end
        end
        assign skew_out[gi] = skew_reg[gi];
    end

    // ---------------- PE mesh ----------------
    logic signed [INP_DATA_WIDTH-1:0] a_q [ARRAY_M][ARRAY_N];
    logic signed [ACC_WIDTH-1:0]      p_q [ARRAY_M][ARRAY_N];

    for (genvar gi = 0; gi < ARRAY_M; gi++) begin : g_row
        for (genvar gj = 0; gj < ARRAY_N; gj++) begin : g_col
            logic signed [WGT_DATA_WIDTH-1:0] w_reg;
            logic signed [INP_DATA_WIDTH-1:0] a_reg;
            logic signed [ACC_WIDTH-1:0]      p_reg;
            logic signed [INP_DATA_WIDTH-1:0] a_in;
            logic signed [ACC_WIDTH-1:0]      p_in;
            logic signed [PROD_W-1:0]         prod;

            if (gj == 0) begin : g_a_edge
                assign a_in = skew_out[gi];
            end else begin : g_a_mesh
                assign a_in = a_q[gi][gj-1];
            end

            if (gi == 0) begin : g_p_edge
                assign p_in = '0;
            end else begin : g_p_mesh
                assign p_in = p_q[gi-1][gj];
            end

            assign prod = PROD_W'(a_in) * PROD_W'(w_reg);

            always_ff @(posedge clk) begin
                if (reset)
                    w_reg <= '0;
                else if (wgt_fire && row_reg == ROW_W'(gi))
                    w_reg <= bus.wgt_data[gj*WGT_DATA_WIDTH +: WGT_DATA_WIDTH];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_reg <= '0;
                    p_reg <= '0;
                end else if (advance) begin
                    a_reg <= a_in;
                    p_reg <= p_in + ACC_WIDTH'(prod);
                end
            end

            assign a_q[gi][gj] = a_reg;
            assign p_q[gi][gj] = p_reg;
        end
    end

    // ---------------- output deskew ----------------
    logic signed [ACC_WIDTH-1:0] col_out [ARRAY_N];

    for (genvar gj = 0; gj < ARRAY_N; gj++) begin : g_deskew
        // Column gj finishes gj cycles after column 0 would, so it gets
        // ARRAY_N-1-gj delay stages plus the shared output register stage.
        localparam int DEPTH = ARRAY_N - gj;
        logic signed [ACC_WIDTH-1:0] dsk_in  [0:DEPTH-1];
        logic signed [ACC_WIDTH-1:0] dsk_reg [0:DEPTH-1];

        always_comb begin
            dsk_in[0] = p_q[ARRAY_M-1][gj];
            for (int k = 1; k < DEPTH; k++) dsk_in[k] = dsk_reg[k-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < DEPTH; k++) dsk_reg[k] <= '0;
            end else if (advance) begin
                for (int k = 0; k < DEPTH - 1; k++) dsk_reg[k] <= dsk_in[k];
                dsk_reg[DEPTH-1] <= out_fn(dsk_in[DEPTH-1]);
            end
        end

        assign col_out[gj] = dsk_reg[DEPTH-1];
    end

    always_comb begin
        bus.out_data = '0;
        for (int n = 0; n < ARRAY_N; n++) bus.out_data[n*ACC_WIDTH +: ACC_WIDTH] = col_out[n];
    end

endmodule
